led_buffer_pwm: RTL and testbench
=================================

LED_BUFFER_PWM -- requirements
Module: led_buffer_pwm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of LED channels (1..32).
REQ-002 SHALL have parameter PWM_BITS, default 4, the brightness resolution (1..8); PWM period P = 2^PWM_BITS-1 cycles.
REQ-003 SHALL have parameter INVERT, default 1; 1 = active-low drive (lit channel outputs 0), 0 = active-high drive.
REQ-004 SHALL have parameter BLINK_DIV, default 1000000, the blink half-period in clock cycles (>=2).
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 data_in  input  WIDTH  channel on/off pattern, 1 = lit.
REQ-008 load  input  1  strobe; captures data_in into the hold register.
REQ-009 oe_n  input  1  output enable, active-low; when high, all channels are forced dark.
REQ-010 brightness  input  PWM_BITS  duty value, 0 = dark, P = fully on.
REQ-011 blink_mask  input  WIDTH  per-channel blink select.
REQ-012 led_out  output  WIDTH  registered drive to the LED pins.
REQ-013 period_start  output  1  registered one-cycle pulse at the first cycle of each PWM period.

Function
REQ-014 SHALL load hold_reg <= data_in on every rising edge with load=1; hold_reg SHALL keep its value otherwise.
REQ-015 SHALL run a free PWM counter cnt counting 0..P-1 and wrapping to 0 after P-1.
REQ-016 SHALL sample brightness into bright_reg only on the edge where cnt wraps to 0, so a brightness change takes effect at the next period boundary and never mid-period.
REQ-017 pwm_on SHALL be (cnt < bright_reg); bright_reg=0 gives no lit cycles and bright_reg=P gives P lit cycles per period.
REQ-018 lit[i] SHALL be hold_reg[i] AND pwm_on AND NOT oe_n AND NOT blink_off[i], where blink_off is defined in Configuration.
REQ-019 led_out[i] SHALL register lit[i] XOR INVERT; a dark channel therefore drives INVERT.
REQ-020 Latency: a load sampled at edge N SHALL appear on led_out at edge N+1; an oe_n change sampled at edge N SHALL appear on led_out at edge N+1.
REQ-021 period_start SHALL be 1 for exactly the cycle in which cnt=0 is used, 1 cycle of every P.
REQ-022 When load=1 and a period boundary fall on the same edge, SHALL capture both data_in and brightness on that edge.
REQ-023 Changing brightness without a load SHALL NOT alter hold_reg; load SHALL NOT alter cnt or bright_reg.
REQ-024 With PWM_BITS=1 (P=1), cnt SHALL stay 0 and period_start SHALL stay 1.

Reset
REQ-025 While rst=1 at an edge, SHALL set hold_reg=0, cnt=0, bright_reg=0, blink counter=0, blink phase=0, period_start=0, and led_out={WIDTH{INVERT}} (all dark).
REQ-026 rst SHALL take priority over load, the counters and oe_n. A reset in the middle of a PWM period SHALL restart the period: cnt=0 on the first edge after rst falls.

Configuration
REQ-027 Macro LED_BUFFER_BLINK_EN: when it is defined, a prescaler counts 0..BLINK_DIV-1. Blink phase toggles on each wrap. blink_off[i] = blink_mask[i] AND (phase=1).
REQ-028 When LED_BUFFER_BLINK_EN is undefined, blink_off SHALL be constantly 0. The blink_mask port remains but is ignored, and no prescaler logic is present.

Verification (WIDTH=8, PWM_BITS=4, P=15, INVERT=1, BLINK_DIV=4)
REQ-029 Reset then idle, brightness=15, oe_n=0: led_out=0xFF (dark) on every cycle.
REQ-030 Load 0xA5 with brightness=15 held across a boundary: from 1 edge after load, led_out=0x5A on every cycle.
REQ-031 data=0x01, brightness=5: bit0 is low for 5 of every 15 cycles, starting in the period_start cycle; the other bits stay 1.
REQ-032 Brightness changed from 15 to 0 at cnt=7: the duty is unchanged until the next period_start, after which led_out=0xFF.
REQ-033 Full brightness with 0xFF loaded and oe_n raised for 3 cycles: led_out=0xFF for exactly those 3 cycles, delayed 1 edge; rst pulsed mid-period: led_out=0xFF, and period_start returns 1 cycle after rst falls.
REQ-034 With LED_BUFFER_BLINK_EN defined, data=0xFF, blink_mask=0x0F, brightness=15: led_out alternates 0x00 and 0x0F every 4 cycles. With the macro undefined, led_out stays 0x00.

Source files
------------

// File: rtl/led_buffer_pwm.sv
// LED hold register with PWM brightness, output enable and optional blink.
// Optional blink prescaler is enabled by defining LED_BUFFER_BLINK_EN.
module led_buffer_pwm #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned INVERT    = 1,
  parameter int unsigned BLINK_DIV = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                load,
  input  logic                oe_n,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [WIDTH-1:0]    blink_mask,
  output logic [WIDTH-1:0]    led_out,
  output logic                period_start
);

  localparam int unsigned PERIOD = (1 << PWM_BITS) - 1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(PERIOD - 1);
  localparam logic [WIDTH-1:0] DARK = {WIDTH{INVERT[0]}};

  logic [WIDTH-1:0]    r_hold;
  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_bright;
  logic                r_oe_n;
  logic [WIDTH-1:0]    r_led;
  logic                r_period_start;

  logic                w_wrap;
  logic                w_pwm_on;
  logic [WIDTH-1:0]    w_blink_off;
  logic [WIDTH-1:0]    w_lit;

  assign w_wrap   = (r_cnt == CNT_LAST);
  assign w_pwm_on = (r_cnt < r_bright);

`ifdef LED_BUFFER_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  // Blink prescaler: phase flips every BLINK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign w_blink_off = blink_mask & {WIDTH{r_phase}};
`else
  logic w_unused_blink_mask;
  assign w_unused_blink_mask = ^blink_mask;
  assign w_blink_off = '0;
`endif

  // oe_n is registered so it lines up with the one-edge load latency.
  assign w_lit = r_hold & {WIDTH{w_pwm_on}} & {WIDTH{~r_oe_n}} & ~w_blink_off;

  // Hold register, PWM counter, period-boundary brightness sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold         <= '0;
      r_cnt          <= '0;
      r_bright       <= '0;
      r_oe_n         <= 1'b1;
      r_led          <= DARK;
      r_period_start <= 1'b0;
    end else begin
      if (load) begin
        r_hold <= data_in;
      end
      if (w_wrap) begin
        r_cnt    <= '0;
        r_bright <= brightness;
      end else begin
        r_cnt <= r_cnt + PWM_BITS'(1);
      end
      r_oe_n         <= oe_n;
      r_led          <= w_lit ^ DARK;
      r_period_start <= (r_cnt == '0);
    end
  end

  assign led_out      = r_led;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_led_buffer_pwm.sv
// Scoreboard bench for led_buffer_pwm: edge-indexed reference model vs. DUT.
module tb_led_buffer_pwm;

  localparam int W  = 8;
  localparam int PB = 4;
  localparam int P  = (1 << PB) - 1;
  localparam int D  = 4;
  localparam logic [W-1:0] DARK = 8'hFF;
`ifdef LED_BUFFER_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  data_in = '0;
  logic          load = 1'b0;
  logic          oe_n = 1'b0;
  logic [PB-1:0] brightness = 4'd15;
  logic [W-1:0]  blink_mask = 8'h0F;
  logic [W-1:0]  led_out;
  logic          period_start;

  always #5 clk = ~clk;

  led_buffer_pwm #(.WIDTH(W), .PWM_BITS(PB), .INVERT(1), .BLINK_DIV(D)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .oe_n(oe_n),
    .brightness(brightness), .blink_mask(blink_mask),
    .led_out(led_out), .period_start(period_start)
  );

  typedef struct {
    logic [W-1:0] led;
    logic         ps;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges since reset release, and the values those edges captured.
  int           m_e = 0;
  logic [W-1:0] m_hold = '0;
  int           m_bright = 0;
  logic         m_oe_prev = 1'b1;

  // Expected outputs after the edge just taken, from the inputs present at it.
  task automatic model_edge();
    exp_t x;
    int pos;
    logic [W-1:0] lit;
    if (rst) begin
      x.led = DARK;
      x.ps  = 1'b0;
      m_e = 0; m_hold = '0; m_bright = 0; m_oe_prev = 1'b1;
    end else begin
      pos = m_e % P;
      lit = m_hold;
      if (pos >= m_bright) lit = '0;
      if (m_oe_prev) lit = '0;
      if (BLINK_EN && ((m_e / D) % 2 == 1)) lit = lit & ~blink_mask;
      x.led = lit ^ DARK;
      x.ps  = (pos == 0);
      if (load) m_hold = data_in;
      if (pos == P - 1) m_bright = int'(brightness);
      m_oe_prev = oe_n;
      m_e++;
    end
    q.push_back(x);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_edge();
    end
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        n_checks++;
        if (led_out !== x.led || period_start !== x.ps) begin
          n_fail++;
          $display("FAIL outputs t=%0t: led_out=%h period_start=%b, required led_out=%h period_start=%b",
                   $time, led_out, period_start, x.led, x.ps);
        end
      end
    end
  end

  initial begin
    // Reset, then idle with nothing loaded.
    tick(3);
    rst = 1'b0;
    tick(20);

    // Load 0xA5 at full brightness.
    data_in = 8'hA5; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(35);

    // Single channel at duty 5.
    data_in = 8'h01; load = 1'b1; brightness = 4'd5;
    tick(1);
    load = 1'b0;
    tick(40);

    // Full brightness, then drop to 0 mid-period at cnt=7.
    brightness = 4'd15;
    tick(16);
    while (m_e % P != 7) tick(1);
    brightness = 4'd0;
    tick(30);

    // All on, pulse oe_n for 3 cycles, then reset mid-period.
    brightness = 4'd15; data_in = 8'hFF; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(20);
    oe_n = 1'b1;
    tick(3);
    oe_n = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);

    // Blink pattern with channels 0..3 selected; load on a boundary edge.
    blink_mask = 8'h0F;
    while (m_e % P != P - 1) tick(1);
    data_in = 8'hFF; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(40);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      load = ($urandom_range(0, 3) == 0);
      data_in = W'($urandom);
      if ($urandom_range(0, 7) == 0) brightness = PB'($urandom_range(0, P));
      oe_n = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) blink_mask = W'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    rst = 1'b0; load = 1'b0;
    tick(2);

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
